// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared UART types and constants (receiver and transmitter).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE       = 16;
  localparam int HALF_BIT         = 8;
  // 100 MHz / (9600 baud * 16 samples), rounded
  localparam int DEFAULT_TICK_DIV = 651;

endpackage

`default_nettype wire

// File: rtl/uart_receiver_if.sv
// ============================================================================
//  Module   : uart_receiver_if
//  Brief    : Byte-side handshake between the UART receiver and its consumer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_receiver_if;

  logic [7:0] rx_data;
  logic       rdrf;
  logic       ferr;
  logic       oerr;
  logic       rdrf_clr;

  modport master (
    output rx_data,
    output rdrf,
    output ferr,
    output oerr,
    input  rdrf_clr
  );

  modport slave (
    input  rx_data,
    input  rdrf,
    input  ferr,
    input  oerr,
    output rdrf_clr
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module   : uart_baud_tick
//  Brief    : Oversample tick divider with synchronous restart for edge alignment.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic Clk_100M,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  localparam int            CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk_100M or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
//  Module   : uart_receiver
//  Brief    : 8N1 UART receiver, 16x oversampled, mid-bit sampling, rdrf handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             Clk_100M,
  input  logic             clr,
  input  logic             RxD,
  uart_receiver_if.master  rx_if
);

  localparam logic [3:0] SAMP_HALF = 4'(HALF_BIT - 1);
  localparam logic [3:0] SAMP_LAST = 4'(OVERSAMPLE - 1);

  logic       sync_q;
  logic       rx_s_q;
  logic       rx_d_q;

  rx_state_t  state_q,   state_d;
  logic [3:0] samp_q,    samp_d;
  logic [2:0] bit_q,     bit_d;
  logic [7:0] shift_q,   shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rdrf_q,    rdrf_d;
  logic       ferr_q,    ferr_d;
  logic       oerr_q,    oerr_d;

  logic       restart;
  logic       tick;

  uart_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_baud_tick (
    .Clk_100M (Clk_100M),
    .clr      (clr),
    .restart  (restart),
    .tick     (tick)
  );

  // Synchroniser and edge-detect flops reset to the idle line level
  always_ff @(posedge Clk_100M or posedge clr) begin
    if (clr) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      sync_q <= RxD;
      rx_s_q <= sync_q;
      rx_d_q <= rx_s_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    ferr_d    = ferr_q;
    oerr_d    = oerr_q;
    rdrf_d    = rdrf_q & ~rx_if.rdrf_clr;
    restart   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          restart = 1'b1;
          samp_d  = '0;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (samp_q == SAMP_HALF) begin
            if (!rx_s_q) begin
              samp_d  = '0;
              bit_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            samp_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (samp_q == SAMP_LAST) begin
            // Load wins over a coincident rdrf_clr; oerr uses pre-clear rdrf
            rx_data_d = shift_q;
            ferr_d    = ~rx_s_q;
            oerr_d    = rdrf_q & ~rx_if.rdrf_clr;
            rdrf_d    = 1'b1;
            samp_d    = '0;
            state_d   = IDLE;
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      samp_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rdrf_q    <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rdrf_q    <= rdrf_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

  assign rx_if.rx_data = rx_data_q;
  assign rx_if.rdrf    = rdrf_q;
  assign rx_if.ferr    = ferr_q;
  assign rx_if.oerr    = oerr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
//  Module   : tb_uart_receiver
//  Brief    : Directed self-checking bench for uart_receiver at TICK_DIV=4.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 64;
  // Cycle (from start-bit drive) of the stop-bit load: 2 sync + 152 ticks * 4
  localparam int LOAD_OFS = 610;

  logic Clk_100M = 1'b0;
  logic clr;
  logic RxD;

  int checks   = 0;
  int failures = 0;

  uart_receiver_if u_if ();

  uart_receiver #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .Clk_100M (Clk_100M),
    .clr      (clr),
    .RxD      (RxD),
    .rx_if    (u_if)
  );

  always #5 Clk_100M = ~Clk_100M;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk_100M);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int bit_clks, input bit ack_on_load);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int c = 0; c < 10 * bit_clks; c++) begin
      RxD           = frame[c / bit_clks];
      u_if.rdrf_clr = ack_on_load && (c == LOAD_OFS);
      step(1);
    end
    RxD           = 1'b1;
    u_if.rdrf_clr = 1'b0;
  endtask

  task automatic ack();
    u_if.rdrf_clr = 1'b1;
    step(1);
    u_if.rdrf_clr = 1'b0;
  endtask

  initial begin
    clr           = 1'b1;
    RxD           = 1'b1;
    u_if.rdrf_clr = 1'b0;
    step(2);
    check("reset_rx_data", 32'(u_if.rx_data), 32'h00);
    check("reset_rdrf",    32'(u_if.rdrf),    32'h0);
    check("reset_ferr",    32'(u_if.ferr),    32'h0);
    check("reset_oerr",    32'(u_if.oerr),    32'h0);
    clr = 1'b0;
    step(20);

    send_frame(8'hA5, 1'b1, BIT_CLKS, 1'b0);
    check("a5_rx_data", 32'(u_if.rx_data), 32'hA5);
    check("a5_rdrf",    32'(u_if.rdrf),    32'h1);
    check("a5_ferr",    32'(u_if.ferr),    32'h0);
    check("a5_oerr",    32'(u_if.oerr),    32'h0);
    ack();
    check("a5_ack_rdrf", 32'(u_if.rdrf), 32'h0);

    RxD = 1'b0;
    step(20);
    RxD = 1'b1;
    step(200);
    check("glitch_rdrf",    32'(u_if.rdrf),    32'h0);
    check("glitch_rx_data", 32'(u_if.rx_data), 32'hA5);

    send_frame(8'h3C, 1'b0, BIT_CLKS, 1'b0);
    step(20);
    check("3c_rx_data", 32'(u_if.rx_data), 32'h3C);
    check("3c_rdrf",    32'(u_if.rdrf),    32'h1);
    check("3c_ferr",    32'(u_if.ferr),    32'h1);
    ack();
    check("3c_ack_ferr_held", 32'(u_if.ferr), 32'h1);
    send_frame(8'h55, 1'b1, BIT_CLKS, 1'b0);
    check("55_rx_data", 32'(u_if.rx_data), 32'h55);
    check("55_ferr",    32'(u_if.ferr),    32'h0);
    check("55_oerr",    32'(u_if.oerr),    32'h0);
    ack();

    send_frame(8'h11, 1'b1, BIT_CLKS, 1'b0);
    send_frame(8'h22, 1'b1, BIT_CLKS, 1'b0);
    check("ovr_rx_data", 32'(u_if.rx_data), 32'h22);
    check("ovr_rdrf",    32'(u_if.rdrf),    32'h1);
    check("ovr_oerr",    32'(u_if.oerr),    32'h1);

    send_frame(8'h11, 1'b1, BIT_CLKS, 1'b0);
    send_frame(8'h22, 1'b1, BIT_CLKS, 1'b1);
    check("ackload_rx_data", 32'(u_if.rx_data), 32'h22);
    check("ackload_rdrf",    32'(u_if.rdrf),    32'h1);
    check("ackload_oerr",    32'(u_if.oerr),    32'h0);

    // Start bit then part of the data bits, abort inside DATA
    RxD = 1'b0;
    step(BIT_CLKS);
    RxD = 1'b1;
    step(100);
    #2 clr = 1'b1;
    #1;
    check("abort_rx_data", 32'(u_if.rx_data), 32'h00);
    check("abort_rdrf",    32'(u_if.rdrf),    32'h0);
    check("abort_ferr",    32'(u_if.ferr),    32'h0);
    check("abort_oerr",    32'(u_if.oerr),    32'h0);
    step(2);
    clr = 1'b0;
    step(10);
    send_frame(8'hF0, 1'b1, BIT_CLKS, 1'b0);
    check("f0_rx_data", 32'(u_if.rx_data), 32'hF0);
    check("f0_rdrf",    32'(u_if.rdrf),    32'h1);
    check("f0_ferr",    32'(u_if.ferr),    32'h0);
    ack();

    send_frame(8'h96, 1'b1, 66, 1'b0);
    check("slow_rx_data", 32'(u_if.rx_data), 32'h96);
    check("slow_ferr",    32'(u_if.ferr),    32'h0);
    check("slow_rdrf",    32'(u_if.rdrf),    32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side counterpart of the team's UART transmitter.
- Deserialises an asynchronous 8N1 serial line (RxD) into bytes, using 16x oversampling with mid-bit sampling.
- Presents each byte with a receive-data-register-full flag (rdrf) that stays set until the consumer acknowledges it.
- Sits between the board RX pin and the byte consumer (command parser / FIFO).

Parameters:
- TICK_DIV, 651, Clk_100M cycles per oversample tick (100 MHz / (9600 × 16), rounded).
- OVERSAMPLE, 16, ticks per bit period; fixed at 16, the half-bit point is tick 8.

Ports:
- Clk_100M  input  1  system clock, 100 MHz, rising edge.
- clr  input  1  reset; asynchronous, active-high.
- RxD  input  1  serial line, idle high, asynchronous to Clk_100M.
- rdrf_clr  input  1  consumer acknowledge; single-cycle pulse clears rdrf.
- rx_data  output  8  last received byte.
- rdrf  output  1  receive data register full.
- ferr  output  1  framing error; stop bit of the last byte sampled low.
- oerr  output  1  overrun; a byte completed while rdrf was already 1.

Behaviour:
- Reset (clr=1, async): rx_data=0x00, rdrf=0, ferr=0, oerr=0, state=IDLE, counters=0. The synchroniser flops reset to 1.
- RxD passes through a 2-flop synchroniser (rx_s). A third flop (rx_d) holds the previous value for edge detection.
- Tick generator: counts 0..TICK_DIV-1 and pulses tick for one cycle at wrap. It restarts from 0 when IDLE detects a start edge, so the frame is phase-aligned to the edge.
- State machine (all counting is done on tick):
  - IDLE: on falling edge (rx_d=1, rx_s=0), clear the tick divider and sample counter, then go to START. A low level without a preceding high does not retrigger, so a break or stuck-low line yields one frame only.
  - START: at sample count 7 (the 8th tick, mid start bit), if rx_s=0, clear the sample counter and bit counter and go to DATA. If rx_s=1, treat it as a glitch and return to IDLE with no output change.
  - DATA: at every 16th tick (mid-bit), shift rx_s into the shift register LSB-first. After bit index 7, go to STOP.
  - STOP: at the 16th tick, sample the stop bit, then take the load actions below and return to IDLE.
- Load actions, all in one cycle:
  - rx_data <= shift register.
  - ferr <= ~rx_s.
  - oerr <= rdrf (pre-load value).
  - rdrf <= 1.
- A byte with a framing error is still delivered, with ferr=1.
- Latency: rdrf rises 1 Clk_100M cycle after the tick that samples the stop bit. That is about 9.5 bit periods after the start edge plus 3 cycles of synchroniser and edge detection.
- rdrf_clr=1 clears rdrf next cycle. If rdrf_clr and a load coincide, the load wins: rdrf stays 1, and oerr is computed from rdrf before the clear. In that case oerr=0, because the consumer has acknowledged.
- ferr and oerr hold until the next load or reset; rdrf_clr does not clear them.
- rdrf_clr while rdrf=0 has no effect.
- RxD activity during DATA/STOP between sample points is ignored. There is no resynchronisation inside a frame.
- clr asserted mid-frame aborts immediately. After release, a new falling edge is required.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP).
  - OVERSAMPLE=16 and HALF_BIT=8 constants.
  - Default TICK_DIV constant, shared with the transmitter.
- One natural sub-module: uart_baud_tick (parameter TICK_DIV; ports Clk_100M, clr, restart, tick). It is reusable by the transmitter.

Test Plan (TICK_DIV=4, so 1 bit = 64 clocks):
- Idle line, then frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB-first, stop 1) -> rx_data=0xA5, rdrf=1, ferr=0, oerr=0; rdrf_clr pulse -> rdrf=0.
- RxD low for 20 clocks (< half bit), then high -> state returns to IDLE, rdrf stays 0, rx_data unchanged.
- Frame 0x3C with stop bit driven 0 -> rx_data=0x3C, rdrf=1, ferr=1. Next clean frame 0x55 -> ferr=0.
- Frames 0x11 then 0x22 back-to-back with no rdrf_clr -> after the second: rx_data=0x22, rdrf=1, oerr=1. Repeat with rdrf_clr on the load cycle -> oerr=0, rdrf=1.
- clr pulse in the middle of DATA -> all outputs 0 immediately. The following full frame 0xF0 is received correctly.
- Baud tolerance: frame 0x96 with the bit period stretched +3% -> rx_data=0x96, ferr=0.
